// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants for param_register_file: default special-register
// addresses, the bit of GOUT that tracks the display mode, and the Galois
// LFSR feedback masks used when RAND is built as an LFSR.
// ---------------------------------------------------------------------------
package regfile_pkg;

    // Default special-register addresses (all distinct, none at address 0).
    localparam int FLAG_ADDR_DEF = 1;
    localparam int DINP_ADDR_DEF = 2;
    localparam int GOUT_ADDR_DEF = 3;
    localparam int DOUT_ADDR_DEF = 4;
    localparam int RAND_ADDR_DEF = 5;
    localparam int MASK_ADDR_DEF = 6;

    // GOUT bit that follows non_signed while GOUT's MSB is set.
    localparam int GOUT_NS_BIT = 5;

    // Right-shifting Galois LFSR feedback masks (maximal length).
    localparam logic [7:0]  LFSR_MASK_8  = 8'hB8;
    localparam logic [15:0] LFSR_MASK_16 = 16'hB400;

    function automatic logic [15:0] lfsr_mask(input int width);
        return (width == 16) ? LFSR_MASK_16 : {8'h00, LFSR_MASK_8};
    endfunction

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for an asynchronous input bus.
// Ports:
//   clk    - sampling clock
//   resetn - asynchronous active-low reset, clears both stages
//   d      - asynchronous input
//   q      - synchronized output, two rising edges after d changes
// ---------------------------------------------------------------------------
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their pre-edge values and the chain really is two flops deep.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/param_register_file.sv
// ---------------------------------------------------------------------------
// param_register_file
// General-purpose register file with NUM_RD combinational read ports, one
// write port and a set of special registers:
//   FLAG - sticky flags, set by flag_in pulses, cleared by test-and-clear
//   DINP - din through a 2-flop synchronizer (read-only)
//   GOUT - general output; bit 5 follows non_signed while bit MSB is set
//   DOUT - data output
//   RAND - free-running counter (or Galois LFSR), read-only
//   MASK - interrupt mask; irq is the registered OR of FLAG & MASK
// Address 0 always reads 0.
// Optional feature macro: REGFILE_LFSR_EN (RAND becomes an LFSR seeded 1).
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   enable               - qualifies software writes and ATC clears
//   non_signed           - display-mode status bit
//   rd_addr / rd_data    - packed read ports, port k in slice k
//   wr_addr/wr_data/wr_en- write port
//   flag_in              - flag set pulses for FLAG[DATA_W-2:0]
//   atc_req/atc_bit/atc_out - test-and-clear of one FLAG bit
//   din                  - asynchronous input feeding DINP
//   gout, dout, flag     - register mirrors
//   irq                  - registered masked-flag interrupt
// ---------------------------------------------------------------------------
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int FLAG_ADDR = FLAG_ADDR_DEF,
    parameter int DINP_ADDR = DINP_ADDR_DEF,
    parameter int GOUT_ADDR = GOUT_ADDR_DEF,
    parameter int DOUT_ADDR = DOUT_ADDR_DEF,
    parameter int RAND_ADDR = RAND_ADDR_DEF,
    parameter int MASK_ADDR = MASK_ADDR_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic                       non_signed,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_en,
    input  logic [DATA_W-2:0]          flag_in,
    input  logic                       atc_req,
    input  logic [$clog2(DATA_W)-1:0]  atc_bit,
    output logic                       atc_out,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          gout,
    output logic [DATA_W-1:0]          dout,
    output logic [DATA_W-1:0]          flag,
    output logic                       irq
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(FLAG_ADDR);
    localparam logic [ADDR_W-1:0] DINP_A = ADDR_W'(DINP_ADDR);
    localparam logic [ADDR_W-1:0] GOUT_A = ADDR_W'(GOUT_ADDR);
    localparam logic [ADDR_W-1:0] DOUT_A = ADDR_W'(DOUT_ADDR);
    localparam logic [ADDR_W-1:0] RAND_A = ADDR_W'(RAND_ADDR);
    localparam logic [ADDR_W-1:0] MASK_A = ADDR_W'(MASK_ADDR);

`ifdef REGFILE_LFSR_EN
    localparam logic [DATA_W-1:0] LFSR_MASK = DATA_W'(lfsr_mask(DATA_W));
    localparam logic [DATA_W-1:0] RAND_RST  = DATA_W'(1);
`else
    localparam logic [DATA_W-1:0] RAND_RST  = '0;
`endif

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DATA_W-1:0] regs_nxt [DEPTH];
    logic [DATA_W-1:0] dinp;
    logic [DATA_W-1:0] rand_nxt;
    logic [DATA_W-1:0] flag_nxt;
    logic [DATA_W-1:0] atc_mask;
    logic              wr_fire;
    logic              atc_clr;

    // DINP lives in the synchronizer's output stage, not in the array.
    sync2 #(.WIDTH(DATA_W)) u_sync2 (
        .clk    (clk),
        .resetn (resetn),
        .d      (din),
        .q      (dinp)
    );

    // Address 0 and the read-only registers silently drop writes.
    assign wr_fire  = enable && wr_en && (wr_addr != '0)
                      && (wr_addr != DINP_A) && (wr_addr != RAND_A);
    assign atc_clr  = enable && atc_req;
    assign atc_mask = DATA_W'(1) << atc_bit;
    assign atc_out  = atc_req & regs[FLAG_A][atc_bit];

    assign gout = regs[GOUT_A];
    assign dout = regs[DOUT_A];
    assign flag = regs[FLAG_A];

    // RAND advances every cycle, independent of enable.
    always_comb begin
`ifdef REGFILE_LFSR_EN
        rand_nxt = regs[RAND_A] >> 1;
        if (regs[RAND_A][0]) rand_nxt = rand_nxt ^ LFSR_MASK;
`else
        rand_nxt = regs[RAND_A] + DATA_W'(1);
`endif
    end

    // FLAG precedence by construction: write, then ATC clear, then the
    // hardware set pulses on top. The MSB has no hardware set source.
    always_comb begin
        flag_nxt = (wr_fire && (wr_addr == FLAG_A)) ? wr_data : regs[FLAG_A];
        if (atc_clr) flag_nxt = flag_nxt & ~atc_mask;
        flag_nxt[DATA_W-2:0] = flag_nxt[DATA_W-2:0] | flag_in;
    end

    // NOTE: every combinational output gets a default first (here the whole
    // array holds), so no path leaves a value unassigned and no latch forms.
    always_comb begin
        regs_nxt = regs;
        if (wr_fire) regs_nxt[wr_addr] = wr_data;
        regs_nxt[FLAG_A] = flag_nxt;
        // The hardware status load wins over a same-cycle software write.
        if (regs[GOUT_A][DATA_W-1]) regs_nxt[GOUT_A][GOUT_NS_BIT] = non_signed;
        regs_nxt[RAND_A] = rand_nxt;
        regs_nxt[DINP_A] = '0;
        regs_nxt[0]      = '0;
    end

    // NOTE: the whole array is reset because every register, not just the
    // special ones, must read 0 after reset; this keeps it out of RAM macros.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == RAND_ADDR) ? RAND_RST : '0;
            end
            irq <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= regs_nxt[i];
            end
            irq <= |(regs[FLAG_A] & regs[MASK_A]);
        end
    end

    // Combinational reads of pre-edge contents: no write bypass.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] = (addr == DINP_A) ? dinp : regs[addr];
    end

endmodule

// File: tb/tb_param_register_file.sv
// ---------------------------------------------------------------------------
// tb_param_register_file
// Self-checking bench for param_register_file with default parameters.
// A behavioural model of the register file is stepped on every rising edge;
// one compare process checks all DUT outputs against it on every falling
// edge. Directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_param_register_file;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          non_signed = 1'b0;
    logic [2*AW-1:0] rd_addr = '0;
    logic [2*DW-1:0] rd_data;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic [DW-2:0] flag_in = '0;
    logic          atc_req = 1'b0;
    logic [2:0]    atc_bit = '0;
    logic          atc_out;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] gout, dout, flag;
    logic          irq;

    param_register_file dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .non_signed (non_signed),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .flag_in    (flag_in),
        .atc_req    (atc_req),
        .atc_bit    (atc_bit),
        .atc_out    (atc_out),
        .din        (din),
        .gout       (gout),
        .dout       (dout),
        .flag       (flag),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_reg [32];
    logic [DW-1:0] m_s1, m_s2;
    logic          m_irq;
    bit            cmp_on = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
`ifdef REGFILE_LFSR_EN
        m_reg[5] = 8'd1;
`endif
        m_s1  = '0;
        m_s2  = '0;
        m_irq = 1'b0;
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == 5'd2) return m_s2;
        if (a == 5'd0) return '0;
        return m_reg[a];
    endfunction

    // One rising edge of the specified behaviour, from pre-edge values.
    task automatic model_step();
        logic [DW-1:0] nx [32];
        logic          wr;
        nx = m_reg;
        wr = enable && wr_en && !(wr_addr inside {5'd0, 5'd2, 5'd5});
        if (wr) nx[wr_addr] = wr_data;
        for (int b = 0; b < DW; b++) begin
            if (b < DW-1 && flag_in[b])                 nx[1][b] = 1'b1;
            else if (enable && atc_req && atc_bit == b) nx[1][b] = 1'b0;
            else if (wr && wr_addr == 5'd1)             nx[1][b] = wr_data[b];
            else                                        nx[1][b] = m_reg[1][b];
        end
        if (m_reg[3][7]) nx[3][5] = non_signed;
`ifdef REGFILE_LFSR_EN
        nx[5] = m_reg[5][0] ? ((m_reg[5] >> 1) ^ 8'hB8) : (m_reg[5] >> 1);
`else
        nx[5] = 8'((int'(m_reg[5]) + 1) % 256);
`endif
        m_irq = |(m_reg[1] & m_reg[6]);
        m_s2  = m_s1;
        m_s1  = din;
        m_reg = nx;
    endtask

    // Compare process: all outputs against the model, away from the edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 2; k++)
                check($sformatf("rd_port%0d", k), 16'(rd_data[k*DW +: DW]),
                      16'(model_read(rd_addr[k*AW +: AW])));
            check("atc_out", 16'(atc_out), 16'(atc_req ? m_reg[1][atc_bit] : 1'b0));
            check("gout", 16'(gout), 16'(m_reg[3]));
            check("dout", 16'(dout), 16'(m_reg[4]));
            check("flag", 16'(flag), 16'(m_reg[1]));
            check("irq",  16'(irq),  16'(m_irq));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        if (resetn) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        enable  = 1'b1;
        wr_en   = 1'b0;
        flag_in = '0;
        atc_req = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        enable = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        repeat (2) cycle();
        resetn = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] v0;
        bit            found;
        bit            seen [256];
        int            ndistinct;

        model_reset();
        idle_inputs();
        #2;
        cmp_on = 1'b1;
        do_reset();

        // reset state
        set_rd(5'd1, 5'd4);
        check("reset_flag", 16'(flag), 16'h0);
        check("reset_irq", 16'(irq), 16'h0);
        check("reset_rd", 16'(rd_data), 16'h0);

        // write / read on both ports, address 0 stays 0
        write(5'd9, 8'h5A);
        set_rd(5'd9, 5'd9);
        check("wr9_rd", 16'(rd_data), 16'h5A5A);
        write(5'd0, 8'h33);
        set_rd(5'd0, 5'd0);
        check("wr0_rd", 16'(rd_data), 16'h0000);

        // no bypass: read of the address being written returns old value
        set_rd(5'd9, 5'd10);
        enable = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 8'hC3; #1;
        check("no_bypass", 16'(rd_data[7:0]), 16'h5A);
        cycle(); wr_en = 1'b0; #1;
        check("after_wr", 16'(rd_data[7:0]), 16'hC3);

        // flag set beats ATC beats write, atc_out shows the old bit
        write(5'd1, 8'h84);
        flag_in = 7'h04; atc_req = 1'b1; atc_bit = 3'd2;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'h00; enable = 1'b1; #1;
        check("atc_old_bit", 16'(atc_out), 16'h1);
        cycle();
        idle_inputs();
        check("flag_prec", 16'(flag), 16'h04);

        // irq latency and clear via ATC
        write(5'd1, 8'h00);
        write(5'd6, 8'h01);
        flag_in = 7'h01;
        cycle();
        flag_in = '0;
        check("flag0_set", 16'(flag), 16'h01);
        check("irq_not_yet", 16'(irq), 16'h0);
        cycle();
        check("irq_up", 16'(irq), 16'h1);
        atc_req = 1'b1; atc_bit = 3'd0;
        cycle();
        atc_req = 1'b0;
        check("flag0_clr", 16'(flag), 16'h00);
        check("irq_still", 16'(irq), 16'h1);
        cycle();
        check("irq_down", 16'(irq), 16'h0);

        // din synchronizer: visible after the 2nd edge, DINP not writable
        din = 8'h00;
        repeat (3) cycle();
        set_rd(5'd2, 5'd2);
        din = 8'h3C;
        cycle();
        check("dinp_edge1", 16'(rd_data[7:0]), 16'h00);
        cycle();
        check("dinp_edge2", 16'(rd_data[7:0]), 16'h3C);
        write(5'd2, 8'hFF);
        check("dinp_ro", 16'(rd_data[7:0]), 16'h3C);

        // randomized operation
        for (int i = 0; i < 600; i++) begin
            enable     = ($urandom_range(0, 3) != 0);
            non_signed = 1'($urandom);
            wr_en      = 1'($urandom);
            wr_addr    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                     : AW'($urandom);
            wr_data    = DW'($urandom);
            flag_in    = ($urandom_range(0, 5) == 0) ? (DW-1)'($urandom) : '0;
            atc_req    = 1'($urandom);
            atc_bit    = 3'($urandom);
            if ($urandom_range(0, 3) == 0) din = DW'($urandom);
            rd_addr    = (2*AW)'($urandom);
            cycle();
        end
        idle_inputs();

        // reset in the middle of a write, with GOUT tracking non_signed
        write(5'd3, 8'h80);
        non_signed = 1'b1;
        cycle();
        check("gout_ns", 16'(gout), 16'hA0);
        enable = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 8'h77;
        #2;
        resetn = 1'b0;
        model_reset();
        cycle();
        set_rd(5'd4, 5'd3);
        check("rst_gout", 16'(gout), 16'h0);
        check("rst_dout", 16'(dout), 16'h0);
        check("rst_irq", 16'(irq), 16'h0);
        check("rst_rd", 16'(rd_data), 16'h0);
        wr_en = 1'b0;
        resetn = 1'b1;
        cycle();
        check("no_wr_kept", 16'(dout), 16'h0);

        // RAND behaviour
        set_rd(5'd5, 5'd5);
`ifdef REGFILE_LFSR_EN
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        ndistinct = 0;
        v0 = rd_data[7:0];
        for (int i = 0; i < 255; i++) begin
            if (rd_data[7:0] != 8'h00 && !seen[rd_data[7:0]]) ndistinct++;
            seen[rd_data[7:0]] = 1'b1;
            cycle();
        end
        check("lfsr_distinct", 16'(ndistinct), 16'd255);
        check("lfsr_period", 16'(rd_data[7:0]), 16'(v0));
`else
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle();
            if (rd_data[7:0] == 8'hFF) found = 1'b1;
        end
        check("rand_reach_ff", 16'(found), 16'h1);
        cycle();
        check("rand_wrap", 16'(rd_data[7:0]), 16'h00);
        cycle();
        check("rand_after_wrap", 16'(rd_data[7:0]), 16'h01);
`endif

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register width in bits (8 or 16).
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of combinational read ports.
REQ-004 SHALL have parameters FLAG_ADDR 1, DINP_ADDR 2, GOUT_ADDR 3, DOUT_ADDR 4, RAND_ADDR 5, MASK_ADDR 6, which set the special-register addresses; all are distinct and non-zero.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, which qualifies software writes and ATC clears.
REQ-008 SHALL have port non_signed, input, 1, the display-mode status bit.
REQ-009 SHALL have ports rd_addr input NUM_RD*ADDR_W and rd_data output NUM_RD*DATA_W, packed, with port k in slice k.
REQ-010 SHALL have ports wr_addr input ADDR_W, wr_data input DATA_W and wr_en input 1.
REQ-011 SHALL have port flag_in, input, DATA_W-1, hardware flag set pulses for bits [DATA_W-2:0].
REQ-012 SHALL have ports atc_req input 1, atc_bit input $clog2(DATA_W) and atc_out output 1, for test-and-clear.
REQ-013 SHALL have ports din input DATA_W, and outputs gout, dout and flag, each DATA_W, which mirror their registers.
REQ-014 SHALL have port irq, output, 1, the registered masked-flag interrupt.

Function
REQ-015 rd_data[k] SHALL equal reg[rd_addr[k]] combinationally; address 0 SHALL always read 0.
REQ-016 A write SHALL occur when enable && wr_en; writes to address 0, DINP_ADDR and RAND_ADDR SHALL be ignored.
REQ-017 A read of the address being written SHALL return the old value until the following edge; there is no bypass.
REQ-018 atc_out SHALL equal flag[atc_bit] when atc_req is high, else 0, combinationally.
REQ-019 FLAG next-state precedence, per bit, highest first: flag_in set (bits < DATA_W-1), then ATC clear (enable && atc_req), then software write, then hold.
REQ-020 FLAG bit DATA_W-1 SHALL be changed only by software write or ATC.
REQ-021 din SHALL pass through a 2-flop synchronizer into DINP; a din change before edge N SHALL be visible in DINP after edge N+1.
REQ-022 When GOUT[DATA_W-1]=1 at an edge, GOUT[5] SHALL load non_signed, overriding any same-cycle software write to that bit.
REQ-023 RAND SHALL advance every cycle regardless of enable: by default +1 modulo 2**DATA_W, wrapping all-ones to 0.
REQ-024 irq SHALL be registered: irq <= |(FLAG & MASK), evaluated on pre-edge values, giving 1 cycle latency.
REQ-025 Out-of-range atc_bit cannot occur, because its width matches DATA_W.

Reset
REQ-026 While resetn=0, all registers, the synchronizer flops and irq SHALL be 0, and RAND SHALL be 0, or 1 under REQ-028.
REQ-027 Reset asserted mid-operation SHALL discard any same-edge write, ATC or flag set; the first update SHALL occur on the first rising edge after deassertion.

Configuration
REQ-028 With REGFILE_LFSR_EN defined, RAND SHALL be a Galois LFSR seeded 1, never reaching 0, using polynomial mask 0xB8 for DATA_W=8 or 0xB400 for DATA_W=16; without it, RAND SHALL be the counter of REQ-023.

Structure
REQ-029 Default special addresses and the LFSR masks SHALL reside in package regfile_pkg.
REQ-030 The synchronizer SHALL be sub-module sync2 (parameter WIDTH).

Verification
REQ-031 Write 0x5A to address 9, then read it on both ports -> 0x5A; write to address 0 -> reads 0.
REQ-032 Same cycle: flag_in[2]=1, ATC bit 2, write FLAG=0x00 -> FLAG=0x04 and atc_out=old bit 2.
REQ-033 MASK=0x01, pulse flag_in[0] at edge N -> FLAG[0]=1 after N, irq=1 after N+1; ATC bit 0 -> irq drops one edge after FLAG clears.
REQ-034 din 0x00->0x3C -> DINP=0x3C exactly after the 2nd edge; write 0xFF to DINP -> ignored.
REQ-035 Counter build: RAND 0xFF -> 0x00 on the next edge; LFSR build: seed 1 -> 255 distinct non-zero values, period 255.
REQ-036 Assert resetn low mid-write with GOUT=0x80 and non_signed=1 -> all outputs 0, irq 0, and no write retained.
